// File: rtl/pcie_s10_tx_fc_gate.sv
// Transmit flow-control gate: subtracts locally granted but not yet reflected credits from the
// hard IP credit counts and grants per-TLP credit requests against the corrected counts.
module pcie_s10_tx_fc_gate #(
  parameter int unsigned HDR_MARGIN  = 0,
  parameter int unsigned DATA_MARGIN = 0,
  parameter int unsigned CDTS_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_ph_cdts,
  input  logic [7:0]  tx_nph_cdts,
  input  logic [7:0]  tx_cplh_cdts,
  input  logic [11:0] tx_pd_cdts,
  input  logic [11:0] tx_npd_cdts,
  input  logic [11:0] tx_cpld_cdts,
  input  logic        tx_hdr_cdts_consumed,
  input  logic        tx_data_cdts_consumed,
  input  logic [1:0]  tx_cdts_type,
  input  logic        tx_cdts_data_value,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [11:0] req_data,
  output logic        req_ready,
  output logic [7:0]  fc_ph_av,
  output logic [7:0]  fc_nph_av,
  output logic [7:0]  fc_cplh_av,
  output logic [11:0] fc_pd_av,
  output logic [11:0] fc_npd_av,
  output logic [11:0] fc_cpld_av,
  output logic        fc_err
);

  localparam int NumTypes = 3;
  // One capture stage plus CDTS_LAT delay stages: a pulse lands CDTS_LAT+1 edges after sampling.
  localparam int SrDepth = int'(CDTS_LAT) + 1;
  localparam logic [7:0]  HdrMargin  = HDR_MARGIN[7:0];
  localparam logic [12:0] DataMargin = DATA_MARGIN[12:0];

  typedef struct packed {
    logic       hdr;
    logic       data;
    logic [1:0] ctype;
    logic       two;
  } cev_t;

  logic [7:0]  w_tx_h     [NumTypes];
  logic [11:0] w_tx_d     [NumTypes];
  logic [7:0]  r_cdts_h   [NumTypes];
  logic [11:0] r_cdts_d   [NumTypes];
  logic [7:0]  r_pend_h   [NumTypes];
  logic [11:0] r_pend_d   [NumTypes];
  logic [7:0]  r_av_h     [NumTypes];
  logic [11:0] r_av_d     [NumTypes];
  logic [7:0]  w_av_h     [NumTypes];
  logic [11:0] w_av_d     [NumTypes];
  logic [7:0]  w_pend_h_d [NumTypes];
  logic [11:0] w_pend_d_d [NumTypes];
  logic [8:0]  w_up_h     [NumTypes];
  logic [8:0]  w_dn_h     [NumTypes];
  logic [12:0] w_up_d     [NumTypes];
  logic [12:0] w_dn_d     [NumTypes];
  logic        w_inc      [NumTypes];
  logic        w_dec      [NumTypes];
  cev_t        r_sr       [SrDepth];
  cev_t        w_cev;
  cev_t        w_exit;
  logic [7:0]  w_sel_h;
  logic [11:0] w_sel_d;
  logic [12:0] w_need;
  logic        w_grant;
  logic        w_err_d;
  logic        r_err;

  assign w_tx_h[0] = tx_ph_cdts;
  assign w_tx_h[1] = tx_nph_cdts;
  assign w_tx_h[2] = tx_cplh_cdts;
  assign w_tx_d[0] = tx_pd_cdts;
  assign w_tx_d[1] = tx_npd_cdts;
  assign w_tx_d[2] = tx_cpld_cdts;

  assign w_cev.hdr   = tx_hdr_cdts_consumed;
  assign w_cev.data  = tx_data_cdts_consumed;
  assign w_cev.ctype = tx_cdts_type;
  assign w_cev.two   = tx_cdts_data_value;
  assign w_exit      = r_sr[SrDepth-1];

  always_comb begin
    for (int t = 0; t < NumTypes; t++) begin
      w_av_h[t] = (r_cdts_h[t] > r_pend_h[t]) ? (r_cdts_h[t] - r_pend_h[t]) : 8'd0;
      w_av_d[t] = (r_cdts_d[t] > r_pend_d[t]) ? (r_cdts_d[t] - r_pend_d[t]) : 12'd0;
    end
  end

  always_comb begin
    w_sel_h = 8'd0;
    w_sel_d = 12'd0;
    case (req_type)
      2'd0: begin w_sel_h = w_av_h[0]; w_sel_d = w_av_d[0]; end
      2'd1: begin w_sel_h = w_av_h[1]; w_sel_d = w_av_d[1]; end
      2'd2: begin w_sel_h = w_av_h[2]; w_sel_d = w_av_d[2]; end
      default: ;
    endcase
    // 13-bit need so a large req_data plus margin can never wrap into a false grant.
    w_need  = {1'b0, req_data} + DataMargin;
    w_grant = req_valid && (req_type != 2'd3) && (w_sel_h > HdrMargin) &&
              ({1'b0, w_sel_d} >= w_need);
  end

  assign req_ready = w_grant;

  always_comb begin
    w_err_d = 1'b0;
    for (int t = 0; t < NumTypes; t++) begin
      w_inc[t]  = w_grant && (req_type == 2'(t));
      w_dec[t]  = (w_exit.ctype == 2'(t));
      w_up_h[t] = {1'b0, r_pend_h[t]} + {8'd0, w_inc[t]};
      w_dn_h[t] = {8'd0, w_dec[t] && w_exit.hdr};
      w_up_d[t] = {1'b0, r_pend_d[t]} + (w_inc[t] ? {1'b0, req_data} : 13'd0);
      w_dn_d[t] = (w_dec[t] && w_exit.data) ? (w_exit.two ? 13'd2 : 13'd1) : 13'd0;

      if (w_up_h[t] < w_dn_h[t]) begin
        w_pend_h_d[t] = 8'd0;
        w_err_d       = 1'b1;
      end else if ((w_up_h[t] - w_dn_h[t]) > 9'd255) begin
        w_pend_h_d[t] = 8'hff;
        w_err_d       = 1'b1;
      end else begin
        w_pend_h_d[t] = w_up_h[t][7:0] - w_dn_h[t][7:0];
      end

      if (w_up_d[t] < w_dn_d[t]) begin
        w_pend_d_d[t] = 12'd0;
        w_err_d       = 1'b1;
      end else if ((w_up_d[t] - w_dn_d[t]) > 13'd4095) begin
        w_pend_d_d[t] = 12'hfff;
        w_err_d       = 1'b1;
      end else begin
        w_pend_d_d[t] = w_up_d[t][11:0] - w_dn_d[t][11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NumTypes; t++) begin
        r_cdts_h[t] <= 8'd0;
        r_cdts_d[t] <= 12'd0;
        r_pend_h[t] <= 8'd0;
        r_pend_d[t] <= 12'd0;
        r_av_h[t]   <= 8'd0;
        r_av_d[t]   <= 12'd0;
      end
      for (int i = 0; i < SrDepth; i++) begin
        r_sr[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int t = 0; t < NumTypes; t++) begin
        r_cdts_h[t] <= w_tx_h[t];
        r_cdts_d[t] <= w_tx_d[t];
        r_pend_h[t] <= w_pend_h_d[t];
        r_pend_d[t] <= w_pend_d_d[t];
        r_av_h[t]   <= w_av_h[t];
        r_av_d[t]   <= w_av_d[t];
      end
      r_sr[0] <= w_cev;
      for (int i = 1; i < SrDepth; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
      r_err <= r_err | w_err_d;
    end
  end

  assign fc_ph_av   = r_av_h[0];
  assign fc_nph_av  = r_av_h[1];
  assign fc_cplh_av = r_av_h[2];
  assign fc_pd_av   = r_av_d[0];
  assign fc_npd_av  = r_av_d[1];
  assign fc_cpld_av = r_av_d[2];
  assign fc_err     = r_err;

endmodule

// File: tb/tb_pcie_s10_tx_fc_gate.sv
// Bench for pcie_s10_tx_fc_gate: two instances (default margins/latency, and margins with zero
// latency) share stimulus and are compared every cycle against a credit-ledger model.
module tb_pcie_s10_tx_fc_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic        hc, dc, cv, rv;
  logic [1:0]  ct, rt;
  logic [11:0] rd;
  logic        rdy0, rdy1, ferr0, ferr1;
  logic [2:0][7:0]  fch0, fch1;
  logic [2:0][11:0] fcd0, fcd1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcie_s10_tx_fc_gate #(.HDR_MARGIN(0), .DATA_MARGIN(0), .CDTS_LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tx_ph_cdts(ph), .tx_nph_cdts(nph), .tx_cplh_cdts(cplh),
    .tx_pd_cdts(pd), .tx_npd_cdts(npd), .tx_cpld_cdts(cpld),
    .tx_hdr_cdts_consumed(hc), .tx_data_cdts_consumed(dc),
    .tx_cdts_type(ct), .tx_cdts_data_value(cv),
    .req_valid(rv), .req_type(rt), .req_data(rd), .req_ready(rdy0),
    .fc_ph_av(fch0[0]), .fc_nph_av(fch0[1]), .fc_cplh_av(fch0[2]),
    .fc_pd_av(fcd0[0]), .fc_npd_av(fcd0[1]), .fc_cpld_av(fcd0[2]),
    .fc_err(ferr0)
  );

  pcie_s10_tx_fc_gate #(.HDR_MARGIN(1), .DATA_MARGIN(2), .CDTS_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .tx_ph_cdts(ph), .tx_nph_cdts(nph), .tx_cplh_cdts(cplh),
    .tx_pd_cdts(pd), .tx_npd_cdts(npd), .tx_cpld_cdts(cpld),
    .tx_hdr_cdts_consumed(hc), .tx_data_cdts_consumed(dc),
    .tx_cdts_type(ct), .tx_cdts_data_value(cv),
    .req_valid(rv), .req_type(rt), .req_data(rd), .req_ready(rdy1),
    .fc_ph_av(fch1[0]), .fc_nph_av(fch1[1]), .fc_cplh_av(fch1[2]),
    .fc_pd_av(fcd1[0]), .fc_npd_av(fcd1[1]), .fc_cpld_av(fcd1[2]),
    .fc_err(ferr1)
  );

  // ---------------- reference model: credit ledger per instance ----------------
  typedef struct {int k; int due; bit h; bit d; int t; int v;} ev_t;
  typedef struct {int t; bit h; int d;} tlp_t;

  int   pend_h [2][3];
  int   pend_d [2][3];
  int   avr_h  [2][3];
  int   avr_d  [2][3];
  int   cq_h   [3];
  int   cq_d   [3];
  bit   merr   [2];
  int   cyc = 0;
  bit   g0_last = 1'b0;
  ev_t  evq [$];
  tlp_t todo [$];

  function automatic int hm(int k);  return (k == 0) ? 0 : 1; endfunction
  function automatic int dm(int k);  return (k == 0) ? 0 : 2; endfunction
  function automatic int lat(int k); return (k == 0) ? 2 : 0; endfunction

  function automatic int mav_h(int k, int t);
    int a = cq_h[t] - pend_h[k][t];
    return (a < 0) ? 0 : a;
  endfunction

  function automatic int mav_d(int k, int t);
    int a = cq_d[t] - pend_d[k][t];
    return (a < 0) ? 0 : a;
  endfunction

  function automatic bit exp_ready(int k);
    int t;
    if (!rv || rt == 2'd3) return 1'b0;
    t = int'(rt);
    return (mav_h(k, t) > hm(k)) && (mav_d(k, t) >= int'(rd) + dm(k));
  endfunction

  function automatic int clampv(int v, int mx, int k);
    if (v < 0) begin merr[k] = 1'b1; return 0; end
    if (v > mx) begin merr[k] = 1'b1; return mx; end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < 3; t++) begin
        pend_h[k][t] = 0; pend_d[k][t] = 0; avr_h[k][t] = 0; avr_d[k][t] = 0;
      end
    for (int t = 0; t < 3; t++) begin cq_h[t] = 0; cq_d[t] = 0; end
    merr[0] = 1'b0; merr[1] = 1'b0;
    evq.delete(); todo.delete();
    g0_last = 1'b0;
  endtask

  task automatic model_step();
    bit   g [2];
    int   dh [2][3];
    int   dd [2][3];
    ev_t  e;
    tlp_t tl;
    for (int k = 0; k < 2; k++) begin
      g[k] = exp_ready(k);
      for (int t = 0; t < 3; t++) begin
        avr_h[k][t] = mav_h(k, t); avr_d[k][t] = mav_d(k, t);
        dh[k][t] = 0; dd[k][t] = 0;
      end
      if (g[k]) begin dh[k][int'(rt)] += 1; dd[k][int'(rt)] += int'(rd); end
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].due == cyc) begin
        e = evq[i];
        if (e.h) dh[e.k][e.t] -= 1;
        if (e.d) dd[e.k][e.t] -= e.v;
        evq.delete(i);
      end
    end
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < 3; t++) begin
        pend_h[k][t] = clampv(pend_h[k][t] + dh[k][t], 255, k);
        pend_d[k][t] = clampv(pend_d[k][t] + dd[k][t], 4095, k);
      end
    if ((hc || dc) && ct != 2'd3)
      for (int k = 0; k < 2; k++) begin
        e.k = k; e.due = cyc + lat(k) + 1; e.h = hc; e.d = dc; e.t = int'(ct);
        e.v = cv ? 2 : 1;
        evq.push_back(e);
      end
    if (g[0]) begin tl.t = int'(rt); tl.h = 1'b1; tl.d = int'(rd); todo.push_back(tl); end
    g0_last = g[0];
    cq_h[0] = int'(ph); cq_h[1] = int'(nph); cq_h[2] = int'(cplh);
    cq_d[0] = int'(pd); cq_d[1] = int'(npd); cq_d[2] = int'(cpld);
    cyc++;
  endtask

  // ---------------- checking ----------------
  function automatic int act_h(int k, int t); return (k == 0) ? int'(fch0[t]) : int'(fch1[t]); endfunction
  function automatic int act_d(int k, int t); return (k == 0) ? int'(fcd0[t]) : int'(fcd1[t]); endfunction
  function automatic int act_rdy(int k); return (k == 0) ? int'(rdy0) : int'(rdy1); endfunction
  function automatic int act_err(int k); return (k == 0) ? int'(ferr0) : int'(ferr1); endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("req_ready[%0d]", k), act_rdy(k), int'(exp_ready(k)));
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("fc_hdr_av[%0d][%0d]", k, t), act_h(k, t), avr_h[k][t]);
        chk($sformatf("fc_data_av[%0d][%0d]", k, t), act_d(k, t), avr_d[k][t]);
      end
      chk($sformatf("fc_err[%0d]", k), act_err(k), int'(merr[k]));
    end
  endtask

  task automatic chk_zero();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready[%0d]", k), act_rdy(k), 0);
      chk($sformatf("rst_err[%0d]", k), act_err(k), 0);
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("rst_hdr_av[%0d][%0d]", k, t), act_h(k, t), 0);
        chk($sformatf("rst_data_av[%0d][%0d]", k, t), act_d(k, t), 0);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
  endtask

  task automatic clr_in();
    ph = '0; nph = '0; cplh = '0; pd = '0; npd = '0; cpld = '0;
    hc = 1'b0; dc = 1'b0; ct = '0; cv = 1'b0; rv = 1'b0; rt = '0; rd = '0;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first, last, n0, n1, hold;
    tlp_t f;
    clr_in();
    model_reset();
    @(negedge clk);
    do_reset();

    // Back-to-back P grants against 4 header credits.
    ph = 8'd4; pd = 12'd64; rv = 1'b1; rt = 2'd0; rd = 12'd8;
    tick();
    first = -1; last = -1; n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rdy0) begin n0++; if (first < 0) first = i; last = i; end
      if (rdy1) n1++;
      tick();
    end
    chk("b2b_grants0", n0, 4);
    chk("b2b_consecutive0", last - first + 1, 4);
    chk("b2b_grants1", n1, 3);
    rv = 1'b0;
    #1;
    chk("b2b_ph_av0", int'(fch0[0]), 0);
    chk("b2b_pd_av0", int'(fcd0[0]), 32);
    chk("b2b_ph_av1", int'(fch1[0]), 1);
    chk("b2b_pd_av1", int'(fcd1[0]), 40);

    // Consume delay: three NP grants, then one NP header consume at edge E.
    do_reset(); clr_in();
    nph = 8'd10; npd = 12'd20;
    tick();
    rv = 1'b1; rt = 2'd1; rd = 12'd0;
    tick(); tick(); tick();
    rv = 1'b0;
    tick();
    #1; chk("dly_pre0", int'(fch0[1]), 7); chk("dly_pre1", int'(fch1[1]), 7);
    hc = 1'b1; ct = 2'd1;
    tick();
    hc = 1'b0;
    #1; chk("dly_e0_0", int'(fch0[1]), 7); chk("dly_e0_1", int'(fch1[1]), 7);
    tick();
    #1; chk("dly_e1_0", int'(fch0[1]), 7); chk("dly_e1_1", int'(fch1[1]), 7);
    tick();
    #1; chk("dly_e2_0", int'(fch0[1]), 7); chk("dly_e2_1", int'(fch1[1]), 8);
    tick();
    #1; chk("dly_e3_0", int'(fch0[1]), 7);
    tick();
    #1; chk("dly_e4_0", int'(fch0[1]), 8);

    // CPL grant in the same cycle a CPL hdr+2-data consume exits (instance 0).
    do_reset(); clr_in();
    cplh = 8'd10; cpld = 12'd100;
    tick();
    rv = 1'b1; rt = 2'd2; rd = 12'd4;
    tick();
    rv = 1'b0; hc = 1'b1; dc = 1'b1; ct = 2'd2; cv = 1'b1;
    tick();
    hc = 1'b0; dc = 1'b0; cv = 1'b0;
    tick(); tick();
    rv = 1'b1; rt = 2'd2; rd = 12'd4;
    #1; chk("sim_grant0", int'(rdy0), 1);
    tick();
    rv = 1'b0;
    #1; chk("sim_pre_cplh0", int'(fch0[2]), 9); chk("sim_pre_cpld0", int'(fcd0[2]), 96);
    tick();
    #1;
    chk("sim_cplh0", int'(fch0[2]), 9); chk("sim_cpld0", int'(fcd0[2]), 94);
    chk("sim_err0", int'(ferr0), 0);
    chk("sim_cplh1", int'(fch1[2]), 9); chk("sim_cpld1", int'(fcd1[2]), 94);

    // Header margin (instance 1) and type 3.
    do_reset(); clr_in();
    nph = 8'd1; npd = 12'd20; rv = 1'b1; rt = 2'd1; rd = 12'd0;
    tick();
    #1; chk("mgn_nph1_blocked", int'(rdy1), 0);
    nph = 8'd2;
    #1; chk("mgn_nph2_same_cycle", int'(rdy1), 0);
    tick();
    #1; chk("mgn_nph2_next_cycle", int'(rdy1), 1);
    rt = 2'd3; ph = 8'd200; nph = 8'd200; cplh = 8'd200;
    pd = 12'd2000; npd = 12'd2000; cpld = 12'd2000;
    tick(); tick();
    #1; chk("type3_ready0", int'(rdy0), 0); chk("type3_ready1", int'(rdy1), 0);

    // Underflow on P data.
    do_reset(); clr_in();
    pd = 12'd10; dc = 1'b1; ct = 2'd0; cv = 1'b0;
    tick();
    dc = 1'b0;
    #1; chk("uf_e0_err0", int'(ferr0), 0); chk("uf_e0_err1", int'(ferr1), 0);
    tick();
    #1; chk("uf_e1_err0", int'(ferr0), 0); chk("uf_e1_err1", int'(ferr1), 1);
    tick();
    #1; chk("uf_e2_err0", int'(ferr0), 0);
    tick();
    #1; chk("uf_e3_err0", int'(ferr0), 1);
    tick();
    #1; chk("uf_pd_av0", int'(fcd0[0]), 10); chk("uf_pd_av1", int'(fcd1[0]), 10);
    repeat (5) tick();
    #1; chk("uf_sticky0", int'(ferr0), 1);

    // Randomized traffic with consumes that follow instance 0's grants.
    do_reset(); clr_in();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        hold = 0;
      end
      if ($urandom_range(0, 19) == 0) begin
        ph = 8'($urandom_range(0, 40)); nph = 8'($urandom_range(0, 40));
        cplh = 8'($urandom_range(0, 40));
        pd = 12'($urandom_range(0, 400)); npd = 12'($urandom_range(0, 400));
        cpld = 12'($urandom_range(0, 400));
      end
      if (!rv || g0_last || hold >= 10) begin
        hold = 0;
        rv = ($urandom_range(0, 3) != 0);
        rt = 2'($urandom_range(0, 3));
        rd = (rt == 2'd1) ? 12'($urandom_range(0, 1)) : 12'($urandom_range(0, 24));
      end else begin
        hold++;
      end
      hc = 1'b0; dc = 1'b0; ct = '0; cv = 1'b0;
      if (todo.size() > 0 && $urandom_range(0, 1) == 1) begin
        f = todo[0];
        hc = f.h; dc = (f.d > 0); cv = (f.d >= 2); ct = 2'(f.t);
        f.h = 1'b0;
        f.d -= dc ? (cv ? 2 : 1) : 0;
        if (f.d == 0) void'(todo.pop_front());
        else todo[0] = f;
      end else if ($urandom_range(0, 149) == 0) begin
        hc = 1'($urandom_range(0, 1)); dc = 1'($urandom_range(0, 1));
        ct = 2'($urandom_range(0, 3)); cv = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
